// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the core (master) and a
// handshaked memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one word load/store at a time,
// waits LATENCY cycles, performs the access on internal storage and returns
// the result over a valid/ready response channel.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [15:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic          misaligned;
  logic          out_of_range;
  logic          bad;
  logic          access;
  logic          mem_we;

  // Decode the captured address and flag the access edge.
  always_comb begin
    idx          = cap_addr[AW+1:2];
    misaligned   = |cap_addr[1:0];
    out_of_range = ({16'd0, cap_addr} >= 32'(4 * DEPTH_WORDS));
    bad          = misaligned | out_of_range;
    access       = (state == WAIT) && (cnt == '0);
    mem_we       = access && cap_write && !bad;
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      cap_write     <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      cap_wstrb     <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            cap_write     <= bus.req_write;
            cap_addr      <= bus.req_addr;
            cap_wdata     <= bus.req_wdata;
            cap_wstrb     <= bus.req_wstrb;
            cnt           <= 4'(LATENCY);
            bus.req_ready <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bad;
            bus.rsp_rdata <= (bad || cap_write) ? '0 : mem[idx];
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Byte-masked store into storage; gated by the registered state, so an
  // asserted reset (which forces IDLE) can never let a pending store commit.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (cap_wstrb[0]) mem[idx][7:0]   <= cap_wdata[7:0];
      if (cap_wstrb[1]) mem[idx][15:8]  <= cap_wdata[15:8];
      if (cap_wstrb[2]) mem[idx][23:16] <= cap_wdata[23:16];
      if (cap_wstrb[3]) mem[idx][31:24] <= cap_wdata[31:24];
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts one load/store request at a time over a valid/ready request channel, then inserts a programmable number of wait states.
- Performs the word access against internal storage and returns the result on a valid/ready response channel.
- Replaces the zero-wait data memory when the core is moved to a handshaked memory interface.

Parameters:
- DEPTH_WORDS, 64: number of 32-bit words of storage; power of two, 4..1024.
- LATENCY, 2: wait-state cycles between request accept and access; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  16  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  store byte enables; bit i enables byte i (bits 8i+7:8i).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset, asynchronous, active-low:
  - State forced to IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Wait counter cleared; captured request fields cleared.
  - Storage contents are not reset.
- States:
  - IDLE:
    - req_ready=1.
    - When req_valid=1 at a rising edge, the request is accepted: capture write/addr/wdata/wstrb, load counter with LATENCY, go to WAIT.
  - WAIT:
    - req_ready=0.
    - If counter != 0, decrement it and stay.
    - If counter == 0, perform the access at this edge, go to RESP.
  - RESP:
    - rsp_valid=1; rsp_rdata and rsp_err held stable.
    - When rsp_ready=1 at an edge, drop rsp_valid, clear rsp_rdata and rsp_err to 0, go to IDLE.
    - req_ready=0 throughout.
- Latency:
  - Request accepted at edge k gives rsp_valid=1 after edge k+LATENCY+1.
  - With LATENCY=0, rsp_valid rises one cycle after accept.
  - Minimum request-to-request spacing is LATENCY+3 cycles with rsp_ready held high: accept, WAIT cycles, RESP, return to IDLE.
- Address decode:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Misaligned if req_addr[1:0] != 0.
  - Out of range if req_addr >= 4*DEPTH_WORDS.
  - Either condition sets rsp_err=1, returns rsp_rdata=0, and leaves storage untouched.
- Store:
  - Only enabled bytes are written; disabled bytes keep their old value.
  - req_wstrb=0000 is a legal no-op store: rsp_err=0.
  - Store responses return rsp_rdata=0.
- Load: rsp_rdata = full 32-bit word at the index, sampled at the access edge. req_wstrb is ignored.
- Request inputs are sampled only at the accept edge; changes afterwards have no effect.
- Back-pressure: rsp_ready=0 holds RESP indefinitely. No new request is accepted while a response is pending.
- Reset mid-operation:
  - In WAIT: the pending access is dropped, and a store in WAIT never commits.
  - In RESP: the response is discarded, and a store that already committed stays committed.
- req_valid asserted during WAIT or RESP is ignored. The core must hold it until req_ready=1 is sampled with it.

Test Plan:
- LATENCY=2, store addr 0x0010 wdata 0xDEADBEEF wstrb 1111, then load 0x0010 -> load rsp_rdata=0xDEADBEEF, rsp_err=0; each rsp_valid rises 3 cycles after its accept edge.
- Partial store wstrb 0101 wdata 0x11223344 over word 0xAABBCCDD at 0x0020, then load -> 0xAA22CC44.
- Misaligned load 0x0013 and out-of-range store 0x0100 (DEPTH_WORDS=64) -> rsp_err=1, rsp_rdata=0; the store does not modify word 0 (aliased index).
- Hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0, and a second req_valid is not accepted until one cycle after rsp_ready=1.
- Assert reset=0 during WAIT of a store to 0x0004 with prior value 0x00000005, then release and load 0x0004 -> 0x00000005; all outputs at reset values while reset=0.
- LATENCY=0 back-to-back loads with req_valid and rsp_ready held high -> rsp_valid one cycle after each accept; accepts spaced 3 cycles apart.
